// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fb_pkg
// Description : Shared definitions for the frame buffer streamer: default
//               frame geometry, an address-width helper, the scanner state
//               encoding and the per-beat marker flags.
// Revision    : 1.0 - initial release
// ============================================================================
package fb_pkg;

    localparam int H_RES_DEF  = 320;
    localparam int V_RES_DEF  = 240;
    localparam int PIX_W_DEF  = 12;
    localparam int RD_LAT_DEF = 1;

    localparam int FRAME_PIX_DEF = H_RES_DEF * V_RES_DEF;

    // Bits needed to index n_words entries (never less than 1).
    function automatic int addr_w_for(input int n_words);
        return (n_words > 1) ? $clog2(n_words) : 1;
    endfunction

    localparam int ADDR_W_DEF = addr_w_for(FRAME_PIX_DEF);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } scan_state_t;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } beat_flags_t;

endpackage
`default_nettype wire

// File: rtl/fb_ram.sv
`default_nettype none
// ============================================================================
// Module      : fb_ram
// Description : Simple dual-port frame RAM, one write port and one read port.
//               Read-first on a same-address collision. RD_LAT = 1 gives a
//               registered read; RD_LAT = 2 adds an output register.
// Ports       : clk                      - clock
//               wr_en / wr_addr / wr_data - write port (already range checked)
//               rd_en / rd_addr           - read request
//               rd_data                   - read data, RD_LAT cycles after rd_en
// Revision    : 1.0 - initial release
// ============================================================================
module fb_ram #(
    parameter int DEPTH  = 76800,
    parameter int ADDR_W = 17,
    parameter int DATA_W = 12,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Separate process from the write: a colliding read sees the old word.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            r_rd_q <= r_mem[rd_addr];
        end
    end

    generate
        if (RD_LAT >= 2) begin : g_out_reg
            logic [DATA_W-1:0] r_rd_q2;
            always_ff @(posedge clk) begin
                r_rd_q2 <= r_rd_q;
            end
            assign rd_data = r_rd_q2;
        end else begin : g_no_out_reg
            assign rd_data = r_rd_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/frame_buffer_streamer.sv
`default_nettype none
// ============================================================================
// Module      : frame_buffer_streamer
// Description : One-frame pixel store with a raster scanner that streams the
//               frame on a valid/ready bus with SOF/EOL/EOF markers.
//               Single-shot or continuous (wrapping) operation.
// Ports       : clk, rst              - clock, synchronous active-high reset
//               wr_en/wr_addr/wr_data - pixel write, linear raster address
//               start                 - pulse to begin streaming at address 0
//               continuous            - 1 = wrap at end of frame, 0 = stop
//               m_valid/m_ready/m_data- output pixel stream
//               m_sof/m_eol/m_eof     - first pixel / end of line / end of frame
//               busy                  - scanning or beats still outstanding
//               frame_done            - pulse when the EOF beat is accepted
// Revision    : 1.0 - initial release
// ============================================================================
module frame_buffer_streamer
    import fb_pkg::*;
#(
    parameter int H_RES  = H_RES_DEF,
    parameter int V_RES  = V_RES_DEF,
    parameter int PIX_W  = PIX_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    input  logic              start,
    input  logic              continuous,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [PIX_W-1:0]  m_data,
    output logic              m_sof,
    output logic              m_eol,
    output logic              m_eof,
    output logic              busy,
    output logic              frame_done
);

    localparam int FRAME_PIX = H_RES * V_RES;
    localparam int RAM_AW    = addr_w_for(FRAME_PIX);
    localparam int DEPTH     = RD_LAT + 1;
    localparam int PTR_W     = addr_w_for(DEPTH);
    localparam int CNT_W     = $clog2(DEPTH + 1);
    localparam int X_W       = addr_w_for(H_RES);
    localparam int Y_W       = addr_w_for(V_RES);

    localparam logic [CNT_W-1:0]  C_DEPTH     = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0]  C_PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [X_W-1:0]    C_X_LAST    = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0]    C_Y_LAST    = Y_W'(V_RES - 1);
    localparam logic [ADDR_W:0]   C_FRAME_PIX = (ADDR_W + 1)'(FRAME_PIX);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == C_PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Frame RAM
    // ------------------------------------------------------------------
    logic              w_wr_ok;
    logic              w_issue;
    logic [RAM_AW-1:0] r_addr;
    logic [PIX_W-1:0]  w_ram_data;

    assign w_wr_ok = wr_en && ({1'b0, wr_addr} < C_FRAME_PIX);

    fb_ram #(
        .DEPTH  (FRAME_PIX),
        .ADDR_W (RAM_AW),
        .DATA_W (PIX_W),
        .RD_LAT (RD_LAT)
    ) u_ram (
        .clk     (clk),
        .wr_en   (w_wr_ok),
        .wr_addr (wr_addr[RAM_AW-1:0]),
        .wr_data (wr_data),
        .rd_en   (w_issue),
        .rd_addr (r_addr),
        .rd_data (w_ram_data)
    );

    // ------------------------------------------------------------------
    // Scanner FSM and raster counters
    // ------------------------------------------------------------------
    scan_state_t      r_state;
    scan_state_t      w_state_nxt;
    logic             w_launch;
    logic [X_W-1:0]   r_x;
    logic [Y_W-1:0]   r_y;
    logic [CNT_W-1:0] r_cred;
    beat_flags_t      w_iss_f;

    assign w_iss_f.sof = (r_x == '0) && (r_y == '0);
    assign w_iss_f.eol = (r_x == C_X_LAST);
    assign w_iss_f.eof = w_iss_f.eol && (r_y == C_Y_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_launch    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start && !busy) begin
                    w_launch    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // Only read when the result is guaranteed a buffer slot.
                w_issue = (r_cred < C_DEPTH);
                if (w_issue && w_iss_f.eof && !continuous) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || w_launch) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
        end else if (w_issue) begin
            if (w_iss_f.eol) begin
                r_x <= '0;
                r_y <= w_iss_f.eof ? '0 : r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
            r_addr <= w_iss_f.eof ? '0 : r_addr + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Flag pipe: markers travel alongside the RAM read
    // ------------------------------------------------------------------
    logic [RD_LAT-1:0] r_pv;
    beat_flags_t       r_pf [RD_LAT];
    logic              w_pipe_v;
    beat_flags_t       w_pipe_f;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pv <= '0;
        end else begin
            r_pv[0] <= w_issue;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        r_pf[0] <= w_iss_f;
        for (int i = 1; i < RD_LAT; i++) begin
            r_pf[i] <= r_pf[i-1];
        end
    end

    assign w_pipe_v = r_pv[RD_LAT-1];
    assign w_pipe_f = r_pf[RD_LAT-1];

    // ------------------------------------------------------------------
    // Output FIFO with fall-through: when empty, the arriving RAM word is
    // presented directly so the first beat costs no extra cycle. A stalled
    // arriving word is pushed and then reappears unchanged as the head.
    // ------------------------------------------------------------------
    logic [PIX_W-1:0] r_fd [DEPTH];
    beat_flags_t      r_ff [DEPTH];
    logic [PTR_W-1:0] r_wp;
    logic [PTR_W-1:0] r_rp;
    logic [CNT_W-1:0] r_cnt;
    logic             w_fifo_ne;
    logic             w_pop;
    logic             w_push;
    logic             w_fpop;
    logic [PIX_W-1:0] w_head_d;
    beat_flags_t      w_head_f;

    assign w_fifo_ne = (r_cnt != '0);
    assign w_head_d  = w_fifo_ne ? r_fd[r_rp] : w_ram_data;
    assign w_head_f  = w_fifo_ne ? r_ff[r_rp] : w_pipe_f;
    assign w_pop     = m_valid && m_ready;
    assign w_push    = w_pipe_v && !(!w_fifo_ne && m_ready);
    assign w_fpop    = w_pop && w_fifo_ne;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fd[r_wp] <= w_ram_data;
            r_ff[r_wp] <= w_pipe_f;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_cnt  <= '0;
            r_cred <= '0;
        end else begin
            if (w_push) begin
                r_wp <= ptr_inc(r_wp);
            end
            if (w_fpop) begin
                r_rp <= ptr_inc(r_rp);
            end
            r_cnt  <= r_cnt + CNT_W'(w_push) - CNT_W'(w_fpop);
            // Credits cover words in flight in the RAM as well as buffered.
            r_cred <= r_cred + CNT_W'(w_issue) - CNT_W'(w_pop);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign m_valid    = w_fifo_ne || w_pipe_v;
    assign m_data     = m_valid ? w_head_d : '0;
    assign m_sof      = m_valid && w_head_f.sof;
    assign m_eol      = m_valid && w_head_f.eol;
    assign m_eof      = m_valid && w_head_f.eof;
    assign frame_done = w_pop && w_head_f.eof;
    assign busy       = (r_state != S_IDLE) || w_fifo_ne || (|r_pv);

endmodule
`default_nettype wire

// File: tb/tb_frame_buffer_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_buffer_streamer
// Description : Self-checking bench for frame_buffer_streamer on a small
//               8x4 frame with a two-cycle RAM read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_buffer_streamer;

    localparam int H   = 8;
    localparam int V   = 4;
    localparam int PW  = 12;
    localparam int AW  = 6;
    localparam int LAT = 2;
    localparam int F   = H * V;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [PW-1:0] wr_data;
    logic          start;
    logic          continuous;
    logic          m_valid;
    logic          m_ready;
    logic [PW-1:0] m_data;
    logic          m_sof;
    logic          m_eol;
    logic          m_eof;
    logic          busy;
    logic          frame_done;

    frame_buffer_streamer #(
        .H_RES  (H),
        .V_RES  (V),
        .PIX_W  (PW),
        .ADDR_W (AW),
        .RD_LAT (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .continuous (continuous),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_sof      (m_sof),
        .m_eol      (m_eol),
        .m_eof      (m_eof),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: frame contents, next expected raster index,
    // a write that becomes visible from the next frame on.
    logic [PW-1:0] mdl_mem [F];
    int            exp_idx = 0;
    int            n_acc   = 0;
    int            n_fd    = 0;
    bit            pend_v  = 1'b0;
    int            pend_a  = 0;
    logic [PW-1:0] pend_d  = '0;
    bit            dense   = 1'b0;
    int            rdy_mode = 0;
    logic [PW-1:0] cap_d [4*F];
    logic [2:0]    cap_f [4*F];

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Downstream ready: always high or 50% random, updated after each edge.
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
        end
    end

    // Compare process, sampled on the falling edge.
    initial begin : compare
        bit            prev_stall;
        logic [PW+2:0] prev_beat;
        prev_stall = 1'b0;
        prev_beat  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", m_valid, 1);
                    chk("stall_hold", {m_data, m_sof, m_eol, m_eof}, prev_beat);
                end
                if (dense) chk("dense_valid", m_valid, 1);
                if (frame_done) n_fd++;
                if (m_valid && m_ready) begin
                    chk("beat_data", m_data, mdl_mem[exp_idx]);
                    chk("beat_flags", {m_sof, m_eol, m_eof},
                        {exp_idx == 0, (exp_idx % H) == H - 1, exp_idx == F - 1});
                    chk("frame_done", frame_done, exp_idx == F - 1);
                    if (n_acc < 4 * F) begin
                        cap_d[n_acc] = m_data;
                        cap_f[n_acc] = {m_sof, m_eol, m_eof};
                    end
                    n_acc++;
                    if (exp_idx == F - 1) begin
                        exp_idx = 0;
                        if (pend_v) begin
                            mdl_mem[pend_a] = pend_d;
                            pend_v = 1'b0;
                        end
                    end else begin
                        exp_idx++;
                    end
                end else begin
                    chk("no_frame_done", frame_done, 0);
                end
                prev_stall = m_valid && !m_ready;
                prev_beat  = {m_data, m_sof, m_eol, m_eof};
            end
        end
    end

    task automatic ram_write(input int a, input logic [PW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_beats(input string name, input int target);
        int k = 0;
        while (n_acc < target && k < 20 * target + 100) begin
            tick();
            k++;
        end
        chk(name, n_acc, target);
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy && k < 20 * F) begin
            tick();
            k++;
        end
        chk(name, busy, 0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; continuous = 1'b0;
        repeat (3) tick();
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_flags", {m_sof, m_eol, m_eof}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        rst = 1'b0;
        tick();

        // 1: ramp frame, ready held high
        for (int a = 0; a < F; a++) begin
            ram_write(a, PW'(a));
            mdl_mem[a] = PW'(a);
        end
        n_acc = 0; n_fd = 0;
        do_start();
        for (int k = 0; k <= LAT; k++) begin
            #4;
            chk("first_valid_latency", m_valid, k == LAT);
            @(posedge clk);
            #1;
        end
        dense = 1'b1;
        wait_beats("t1_beats", F);
        dense = 1'b0;
        chk("t1_busy_after_eof", busy, 0);
        chk("t1_done_count", n_fd, 1);
        chk("t1_b0_data", cap_d[0], 12'h000);
        chk("t1_b0_flags", cap_f[0], 3'b100);
        chk("t1_b7_data", cap_d[7], 12'h007);
        chk("t1_b7_flags", cap_f[7], 3'b010);
        chk("t1_b8_flags", cap_f[8], 3'b000);
        chk("t1_b31_data", cap_d[31], 12'h01F);
        chk("t1_b31_flags", cap_f[31], 3'b011);

        // 2: same frame, random backpressure
        rdy_mode = 1;
        n_acc = 0; n_fd = 0;
        do_start();
        wait_beats("t2_beats", F);
        wait_idle("t2_idle");
        chk("t2_done_count", n_fd, 1);

        // 3: random data, continuous, then stop after the third frame
        rdy_mode = 0;
        tick();
        for (int a = 0; a < F; a++) begin
            logic [PW-1:0] d;
            d = PW'($urandom);
            ram_write(a, d);
            mdl_mem[a] = d;
        end
        continuous = 1'b1;
        n_acc = 0; n_fd = 0;
        do_start();
        repeat (LAT + 1) tick();
        dense = 1'b1;
        wait_beats("t3_mid", 2 * F + F / 2);
        continuous = 1'b0;
        wait_beats("t3_beats", 3 * F);
        dense = 1'b0;
        chk("t3_busy_after_eof", busy, 0);
        repeat (2 * LAT + 4) tick();
        chk("t3_stopped", m_valid, 0);
        chk("t3_total", n_acc, 3 * F);
        chk("t3_done_count", n_fd, 3);
        chk("t3_wrap_sof", cap_f[F], 3'b100);
        chk("t3_wrap_data", cap_d[F], mdl_mem[0]);

        // 4: reset in the middle of the second frame
        continuous = 1'b1;
        rdy_mode = 1;
        n_acc = 0;
        do_start();
        wait_beats("t4_pre_reset", F + 10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_idx = 0;
        continuous = 1'b0;
        chk("t4_rst_valid", m_valid, 0);
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_data", m_data, 0);
        rdy_mode = 0;
        tick();
        n_acc = 0; n_fd = 0;
        do_start();
        wait_beats("t4_beats", F);
        wait_idle("t4_idle");
        chk("t4_done_count", n_fd, 1);
        chk("t4_first_sof", cap_f[0], 3'b100);

        // 5: colliding write is read-first; out-of-range write ignored
        ram_write(5, 12'h123);
        mdl_mem[5] = 12'h123;
        continuous = 1'b1;
        n_acc = 0; n_fd = 0;
        do_start();
        repeat (5) @(posedge clk);
        #1;
        dense = 1'b1;
        pend_a = 5; pend_d = 12'hABC; pend_v = 1'b1;
        ram_write(5, 12'hABC);
        wait_beats("t5_f1", F + 4);
        ram_write(F, 12'hFFF);
        wait_beats("t5_mid", 2 * F + F / 2);
        continuous = 1'b0;
        wait_beats("t5_beats", 3 * F);
        dense = 1'b0;
        wait_idle("t5_idle");
        chk("t5_old_value", cap_d[5], 12'h123);
        chk("t5_new_value", cap_d[F + 5], 12'hABC);
        chk("t5_done_count", n_fd, 3);

        // 6: start pulses while busy are ignored
        rdy_mode = 1;
        n_acc = 0; n_fd = 0;
        do_start();
        wait_beats("t6_half", F / 2);
        do_start();
        wait_beats("t6_tail", F - 1);
        do_start();
        wait_beats("t6_beats", F);
        wait_idle("t6_idle");
        repeat (2 * LAT + 6) tick();
        chk("t6_stopped", m_valid, 0);
        chk("t6_total", n_acc, F);
        chk("t6_done_count", n_fd, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
